// File: rtl/pkt_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pkt_buf_pkg
//  Brief   : Shared constants, descriptor type and read-FSM states for the
//            per-port packet buffer controller.
//  Rev     : 1.0  initial release
// ============================================================================
package pkt_buf_pkg;

   localparam int DATA_WIDTH    = 289;   // 256 data + 32 keep + 1 last
   localparam int LAST_BIT      = 0;
   localparam int DESC_ADDR_MAX = 16;    // widest address a descriptor carries
   localparam int DESC_LEN_MAX  = 16;

   typedef struct packed {
      logic [DESC_ADDR_MAX-1:0] addr;
      logic [DESC_LEN_MAX-1:0]  len;
   } desc_t;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_READ  = 2'd1,
      RD_DRAIN = 2'd2
   } rd_state_e;

   function automatic desc_t pack_desc(input logic [DESC_ADDR_MAX-1:0] addr,
                                       input logic [DESC_LEN_MAX-1:0]  len);
      desc_t d;
      d.addr = addr;
      d.len  = len;
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : pkt_buffer_ctrl_if
//  Brief   : Packet-in, descriptor, dequeue, packet-out and BRAM signals of
//            one packet buffer controller instance.
//  Rev     : 1.0  initial release
// ============================================================================
interface pkt_buffer_ctrl_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int LEN_WIDTH  = 8,
   parameter int DATA_WIDTH = pkt_buf_pkg::DATA_WIDTH
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  desc_valid;
   logic [ADDR_WIDTH-1:0] desc_addr;
   logic [LEN_WIDTH-1:0]  desc_len;
   logic                  drop_pulse;
   logic                  deq_valid;
   logic [ADDR_WIDTH-1:0] deq_addr;
   logic [LEN_WIDTH-1:0]  deq_len;
   logic                  deq_ready;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;
   logic                  bram_wea;
   logic [ADDR_WIDTH-1:0] bram_addra;
   logic [DATA_WIDTH-1:0] bram_dina;
   logic [ADDR_WIDTH-1:0] bram_addrb;
   logic [DATA_WIDTH-1:0] bram_doutb;

   modport master (
      output in_valid, in_data, deq_valid, deq_addr, deq_len, out_ready, bram_doutb,
      input  desc_valid, desc_addr, desc_len, drop_pulse, deq_ready,
             out_valid, out_data, bram_wea, bram_addra, bram_dina, bram_addrb
   );

   modport slave (
      input  in_valid, in_data, deq_valid, deq_addr, deq_len, out_ready, bram_doutb,
      output desc_valid, desc_addr, desc_len, drop_pulse, deq_ready,
             out_valid, out_data, bram_wea, bram_addra, bram_dina, bram_addrb
   );
endinterface
`default_nettype wire

// File: rtl/pkt_buf_out_skid.sv
`default_nettype none
// ============================================================================
//  Module  : pkt_buf_out_skid
//  Brief   : Two-entry output skid buffer absorbing the one-cycle BRAM read
//            latency so the read side can stream at one word per clock.
//  Rev     : 1.0  initial release
// ============================================================================
module pkt_buf_out_skid
   import pkt_buf_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_count
);
   logic [1:0]       r_count;
   logic [WIDTH-1:0] r_data0;
   logic [WIDTH-1:0] r_data1;
   logic             w_pop;

   assign w_pop   = o_valid & i_ready;
   assign o_valid = (r_count != 2'd0);
   assign o_data  = r_data0;
   assign o_count = r_count;

   // r_data0 is always the head; r_data1 only holds data when two words wait.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= 2'd0;
         r_data0 <= '0;
         r_data1 <= '0;
      end else begin
         case ({i_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_data0 <= i_data;
               else                 r_data1 <= i_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_data0 <= r_data1;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd2) begin
                  r_data0 <= r_data1;
                  r_data1 <= i_data;
               end else begin
                  r_data0 <= i_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/pkt_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : pkt_buffer_ctrl
//  Brief   : Write/read sequencer for one circular per-port packet BRAM:
//            commits packets as descriptors and replays dequeued packets.
//  Rev     : 1.0  initial release
// ============================================================================
module pkt_buffer_ctrl
   import pkt_buf_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int LEN_WIDTH  = 8
) (
   input  logic             clk,
   input  logic             rst,
   pkt_buffer_ctrl_if.slave io_bus
);
   localparam logic [ADDR_WIDTH:0]   c_depth    = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0]   c_used_one = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0]  c_len_one  = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0]  c_max_len  = '1;

   // ---------------- write side ----------------
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_pkt_start;
   logic [LEN_WIDTH-1:0]  r_pkt_len;
   logic                  r_dropping;
   logic [ADDR_WIDTH:0]   r_used;
   logic                  r_desc_valid;
   logic [ADDR_WIDTH-1:0] r_desc_addr;
   logic [LEN_WIDTH-1:0]  r_desc_len;
   logic                  r_drop_pulse;

   logic                  w_last;
   logic                  w_accept;
   logic                  w_wr;
   logic                  w_drop;
   logic                  w_pop;
   logic [ADDR_WIDTH:0]   w_used_next;

   assign w_last   = io_bus.in_data[LAST_BIT];
   assign w_accept = io_bus.in_valid & ~r_dropping;
   assign w_wr     = w_accept & (r_used != c_depth) & (r_pkt_len < c_max_len);
   assign w_drop   = w_accept & ~w_wr;

   // A drop hands back the words already written for the partial packet.
   always_comb begin
      w_used_next = r_used;
      if (w_wr)   w_used_next = w_used_next + c_used_one;
      if (w_pop)  w_used_next = w_used_next - c_used_one;
      if (w_drop) w_used_next = w_used_next - (ADDR_WIDTH+1)'(r_pkt_len);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_pkt_start  <= '0;
         r_pkt_len    <= '0;
         r_dropping   <= 1'b0;
         r_used       <= '0;
         r_desc_valid <= 1'b0;
         r_desc_addr  <= '0;
         r_desc_len   <= '0;
         r_drop_pulse <= 1'b0;
      end else begin
         r_used       <= w_used_next;
         r_desc_valid <= 1'b0;
         r_drop_pulse <= 1'b0;
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + c_addr_one;
            if (w_last) begin
               r_desc_valid <= 1'b1;
               r_desc_addr  <= r_pkt_start;
               r_desc_len   <= r_pkt_len + c_len_one;
               r_pkt_start  <= r_wr_ptr + c_addr_one;
               r_pkt_len    <= '0;
            end else begin
               r_pkt_len <= r_pkt_len + c_len_one;
            end
         end else if (w_drop) begin
            r_wr_ptr  <= r_pkt_start;
            r_pkt_len <= '0;
            if (w_last) r_drop_pulse <= 1'b1;
            else        r_dropping   <= 1'b1;
         end else if (io_bus.in_valid & r_dropping & w_last) begin
            r_dropping   <= 1'b0;
            r_drop_pulse <= 1'b1;
            r_pkt_len    <= '0;
         end
      end
   end

   // ---------------- read side ----------------
   rd_state_e             r_state;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [LEN_WIDTH-1:0]  r_rd_cnt;
   logic                  r_inflight;
   logic                  r_deq_ready;

   logic [1:0]            w_skid_cnt;
   logic [1:0]            w_occ;
   logic                  w_issue;
   logic                  w_out_valid;
   logic [DATA_WIDTH-1:0] w_out_data;

   // Occupancy the skid will hold next cycle if nothing new is issued.
   assign w_pop   = w_out_valid & io_bus.out_ready;
   assign w_occ   = w_skid_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
   assign w_issue = (r_state == RD_READ) & (w_occ < 2'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RD_IDLE;
         r_rd_ptr    <= '0;
         r_rd_cnt    <= '0;
         r_inflight  <= 1'b0;
         r_deq_ready <= 1'b1;
      end else begin
         r_inflight <= w_issue;
         case (r_state)
            RD_IDLE: begin
               if (io_bus.deq_valid) begin
                  r_rd_ptr    <= io_bus.deq_addr;
                  r_rd_cnt    <= io_bus.deq_len;
                  r_state     <= RD_READ;
                  r_deq_ready <= 1'b0;
               end
            end
            RD_READ: begin
               if (w_issue) begin
                  r_rd_ptr <= r_rd_ptr + c_addr_one;
                  r_rd_cnt <= r_rd_cnt - c_len_one;
                  if (r_rd_cnt == c_len_one) r_state <= RD_DRAIN;
               end
            end
            RD_DRAIN: begin
               if (!r_inflight && (w_skid_cnt == 2'd0)) begin
                  r_state     <= RD_IDLE;
                  r_deq_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= RD_IDLE;
               r_deq_ready <= 1'b1;
            end
         endcase
      end
   end

   pkt_buf_out_skid #(
      .WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_inflight),
      .i_data  (io_bus.bram_doutb),
      .i_ready (io_bus.out_ready),
      .o_valid (w_out_valid),
      .o_data  (w_out_data),
      .o_count (w_skid_cnt)
   );

   assign io_bus.bram_wea   = w_wr;
   assign io_bus.bram_addra = r_wr_ptr;
   assign io_bus.bram_dina  = w_wr ? io_bus.in_data : '0;
   assign io_bus.bram_addrb = r_rd_ptr;
   assign io_bus.desc_valid = r_desc_valid;
   assign io_bus.desc_addr  = r_desc_addr;
   assign io_bus.desc_len   = r_desc_len;
   assign io_bus.drop_pulse = r_drop_pulse;
   assign io_bus.deq_ready  = r_deq_ready;
   assign io_bus.out_valid  = w_out_valid;
   assign io_bus.out_data   = w_out_data;

endmodule
`default_nettype wire

// File: tb/tb_pkt_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pkt_buffer_ctrl
//  Brief   : Directed self-checking bench for pkt_buffer_ctrl on a 16-word
//            buffer with a behavioural one-cycle-latency BRAM.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pkt_buffer_ctrl;
   import pkt_buf_pkg::*;

   localparam int AW = 4;
   localparam int LW = 8;
   localparam int DW = DATA_WIDTH;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pkt_buffer_ctrl_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)) bus ();

   pkt_buffer_ctrl #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   logic [DW-1:0] mem [2**AW];
   always @(posedge clk) begin
      if (bus.bram_wea) mem[bus.bram_addra] <= bus.bram_dina;
      bus.bram_doutb <= mem[bus.bram_addrb];
   end

   int            cyc = 0;
   logic [AW-1:0] wa_q[$];
   desc_t         desc_q[$];
   logic [DW-1:0] out_q[$];
   int            out_cyc[$];
   int            drop_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.bram_wea) wa_q.push_back(bus.bram_addra);
      if (bus.desc_valid)
         desc_q.push_back(pack_desc(DESC_ADDR_MAX'(bus.desc_addr), DESC_LEN_MAX'(bus.desc_len)));
      if (bus.drop_pulse) drop_cnt++;
      if (bus.out_valid && bus.out_ready) begin
         out_q.push_back(bus.out_data);
         out_cyc.push_back(cyc);
      end
   end

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int tag, input bit last);
      return {256'(tag), 32'hFFFF_FFFF, last};
   endfunction

   function automatic logic [31:0] dsc(input int a, input int l);
      return {16'(a), 16'(l)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input int n, input int tag);
      for (int i = 0; i < n; i++) begin
         tick();
         bus.in_valid = 1'b1;
         bus.in_data  = mk(tag + i, i == n - 1);
      end
   endtask

   task automatic idle_in();
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      tick();
      tick();
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus.deq_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("deq_ready_wait", bus.deq_ready, 1'b1);
   endtask

   task automatic deq(input int a, input int l);
      wait_ready();
      bus.deq_valid = 1'b1;
      bus.deq_addr  = AW'(a);
      bus.deq_len   = LW'(l);
      tick();
      bus.deq_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b, bd, ob, d0, n;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.deq_valid = 1'b0;
      bus.deq_addr  = '0;
      bus.deq_len   = '0;
      bus.out_ready = 1'b1;

      // reset state
      do_reset();
      chk("rst_desc_valid", bus.desc_valid, 1'b0);
      chk("rst_drop_pulse", bus.drop_pulse, 1'b0);
      chk("rst_deq_ready",  bus.deq_ready,  1'b1);
      chk("rst_out_valid",  bus.out_valid,  1'b0);
      chk("rst_bram_wea",   bus.bram_wea,   1'b0);
      chk("rst_bram_addra", bus.bram_addra, 0);
      chk("rst_bram_addrb", bus.bram_addrb, 0);
      chk("rst_used",       dut.r_used,     0);

      // 3-word packet from address 0
      b = wa_q.size(); bd = desc_q.size();
      send_pkt(3, 'h10);
      idle_in();
      chk("t1_wr_count", wa_q.size() - b, 3);
      for (int i = 0; i < 3; i++) chk("t1_addra", wa_q[b + i], i);
      chk("t1_desc_count", desc_q.size() - bd, 1);
      chk("t1_desc", desc_q[bd], dsc(0, 3));

      // back-to-back packets of 1, 2, 4 words
      do_reset();
      bd = desc_q.size(); d0 = drop_cnt;
      send_pkt(1, 'h20);
      send_pkt(2, 'h30);
      send_pkt(4, 'h40);
      idle_in();
      chk("t2_desc_count", desc_q.size() - bd, 3);
      chk("t2_desc0", desc_q[bd],     dsc(0, 1));
      chk("t2_desc1", desc_q[bd + 1], dsc(1, 2));
      chk("t2_desc2", desc_q[bd + 2], dsc(3, 4));
      chk("t2_no_drop", drop_cnt - d0, 0);
      chk("t2_used", dut.r_used, 7);

      // readout at full rate
      ob = out_q.size();
      deq(3, 4);
      wait_ready();
      chk("t3_out_count", out_q.size() - ob, 4);
      for (int i = 0; i < 4; i++) begin
         chk("t3_out_data", out_q[ob + i], mk('h40 + i, i == 3));
         chk("t3_out_cycle", out_cyc[ob + i] - out_cyc[ob], i);
      end
      chk("t3_used", dut.r_used, 3);

      // same packet with out_ready toggling every cycle
      ob = out_q.size();
      bus.out_ready = 1'b0;
      deq(3, 4);
      n = 0;
      while ((out_q.size() - ob < 4 || bus.deq_ready !== 1'b1) && n < 60) begin
         tick();
         bus.out_ready = ~bus.out_ready;
         n++;
      end
      bus.out_ready = 1'b1;
      repeat (4) tick();
      chk("t3b_out_count", out_q.size() - ob, 4);
      for (int i = 0; i < 4; i++) chk("t3b_out_data", out_q[ob + i], mk('h40 + i, i == 3));

      // wrap-around at the top of the buffer
      do_reset();
      send_pkt(7, 'h50);
      send_pkt(7, 'h58);
      idle_in();
      deq(0, 7);
      deq(7, 7);
      wait_ready();
      tick();
      chk("t4_used_empty", dut.r_used, 0);
      b = wa_q.size(); bd = desc_q.size(); ob = out_q.size();
      send_pkt(4, 'h60);
      idle_in();
      chk("t4_wr_count", wa_q.size() - b, 4);
      chk("t4_addra0", wa_q[b],     14);
      chk("t4_addra1", wa_q[b + 1], 15);
      chk("t4_addra2", wa_q[b + 2], 0);
      chk("t4_addra3", wa_q[b + 3], 1);
      chk("t4_desc", desc_q[bd], dsc(14, 4));
      deq(14, 4);
      wait_ready();
      chk("t4_out_count", out_q.size() - ob, 4);
      for (int i = 0; i < 4; i++) chk("t4_out_data", out_q[ob + i], mk('h60 + i, i == 3));
      chk("t4_used", dut.r_used, 0);

      // overflow: 14 words resident, 5-word packet does not fit
      bd = desc_q.size();
      send_pkt(14, 'h70);
      idle_in();
      chk("t5_fill_desc", desc_q[bd], dsc(2, 14));
      chk("t5_fill_used", dut.r_used, 14);
      b = wa_q.size(); bd = desc_q.size(); d0 = drop_cnt;
      send_pkt(5, 'h80);
      idle_in();
      chk("t5_drop_pulse", drop_cnt - d0, 1);
      chk("t5_no_desc", desc_q.size() - bd, 0);
      chk("t5_partial_writes", wa_q.size() - b, 2);
      chk("t5_used_restored", dut.r_used, 14);
      chk("t5_wr_ptr_rollback", dut.r_wr_ptr, 0);
      send_pkt(2, 'h90);
      idle_in();
      chk("t5_next_desc", desc_q[bd], dsc(0, 2));
      chk("t5_used_full", dut.r_used, 16);
      ob = out_q.size();
      deq(2, 14);
      deq(0, 2);
      wait_ready();
      chk("t5_out_count", out_q.size() - ob, 16);
      chk("t5_out_w0", out_q[ob + 14], mk('h90, 1'b0));
      chk("t5_out_w1", out_q[ob + 15], mk('h91, 1'b1));

      // reset in the middle of a read
      do_reset();
      send_pkt(8, 'hA0);
      idle_in();
      bus.out_ready = 1'b0;
      deq(0, 8);
      tick();
      tick();
      chk("t6_busy_deq_ready", bus.deq_ready, 1'b0);
      chk("t6_busy_out_valid", bus.out_valid, 1'b1);
      rst = 1'b1;
      tick();
      chk("t6_rst_out_valid", bus.out_valid, 1'b0);
      chk("t6_rst_deq_ready", bus.deq_ready, 1'b1);
      chk("t6_rst_used",      dut.r_used,    0);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      ob = out_q.size();
      repeat (5) tick();
      chk("t6_no_stale_out", out_q.size() - ob, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
